approx_err_monitor: RTL

//  Downstream error-metric stage for the approximate ripple-carry adders. Consumes operand

---
 rtl/approx_err_monitor_if.sv | 21 ++
 rtl/approx_err_monitor.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/approx_err_monitor_if.sv
// Operand/sum beat handshake between the approximate adder and its monitor.
// The master drives a beat; the slave accepts it with in_ready.
interface approx_err_monitor_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W:0]   approx_sum;

    modport master (
        output in_valid, in1, in2, approx_sum,
        input  in_ready
    );

    modport slave (
        input  in_valid, in1, in2, approx_sum,
        output in_ready
    );
endinterface

// File: rtl/approx_err_monitor.sv
// Error-metric stage for approximate adders: sum, max and count of |exact - approx|.
// Optional signed bias output (sum of approx - exact) when APPROX_MON_BIAS_EN is defined.
module approx_err_monitor #(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = W + 1 + CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_samples,
    approx_err_monitor_if.slave     bus,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        err_sum,
    output logic [W:0]              err_max,
    output logic [CNT_W-1:0]        err_cnt
`ifdef APPROX_MON_BIAS_EN
    ,
    output logic signed [ACC_W:0]   err_bias
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] acc_cnt;
    logic             ready_c;
    logic             accept;
    logic             last_beat;
    logic             start_acc;
    logic             v1;
    logic [W:0]       ex1;
    logic [W:0]       ap1;
    logic [W:0]       d;

    assign accept    = bus.in_valid & ready_c;
    assign last_beat = (acc_cnt == n_lat - CNT_W'(1));
    assign start_acc = start & ((state == IDLE) | (state == DONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state logic; DRAIN ends once S1 is empty since S2 commits that same edge
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    nxt = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && last_beat) begin
                    nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!v1) begin
                    nxt = DONE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        ready_c = (state == RUN) && (acc_cnt < n_lat);
        busy    = (state == RUN) || (state == DRAIN);
        done    = (state == DONE);
    end

    assign bus.in_ready = ready_c;

    // Absolute error of the beat held in S1
    always_comb begin
        if (ex1 >= ap1) begin
            d = ex1 - ap1;
        end else begin
            d = ap1 - ex1;
        end
    end

    // S1 capture, accepted-beat counter and S2 statistics update
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat   <= '0;
            acc_cnt <= '0;
            v1      <= 1'b0;
            ex1     <= '0;
            ap1     <= '0;
            err_sum <= '0;
            err_max <= '0;
            err_cnt <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                ex1     <= {1'b0, bus.in1} + {1'b0, bus.in2};
                ap1     <= bus.approx_sum;
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (start_acc) begin
                n_lat   <= num_samples;
                acc_cnt <= '0;
                err_sum <= '0;
                err_max <= '0;
                err_cnt <= '0;
            end else if (v1) begin
                err_sum <= err_sum + ACC_W'(d);
                if (d > err_max) begin
                    err_max <= d;
                end
                err_cnt <= err_cnt + CNT_W'(d != '0);
            end
        end
    end

`ifdef APPROX_MON_BIAS_EN
    logic signed [W+1:0] delta;

    assign delta = $signed({1'b0, ap1}) - $signed({1'b0, ex1});

    // Signed bias accumulator, same timing as the other statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            err_bias <= '0;
        end else if (start_acc) begin
            err_bias <= '0;
        end else if (v1) begin
            err_bias <= err_bias + {{CNT_W{delta[W+1]}}, delta};
        end
    end
`endif

endmodule
